fetch_stage: RTL
================

Name: fetch_stage

Overview:
- First stage of the five-stage MIPS pipeline.
- Owns the PC and drives the synchronous instruction ROM.
- Hands {pc, inst, fetch_error} to decode over IF_ID_bus.
- Receiving end of the write-back exception/eret redirect (exc_bus) and of the decode branch redirect (jbr_bus).
- Detects misaligned-PC fetch errors, which write-back reports as AdEL (Cause code 4).

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.
NOP_INST, 32'h00000000, instruction word substituted on a fetch error.

Ports:
clk  in  1  clock.
reset  in  1  reset; synchronous, active-high.
IF_valid  in  1  fetch stage slot valid (from pipeline control).
next_fetch  in  1  decode accepts the current IF_ID_bus this cycle; advance PC.
inst_addr  out  32  instruction ROM address; equals pc.
inst_rdata  in  32  ROM read data, valid one cycle after inst_addr is stable.
jbr_bus  in  33  {jbr_taken, jbr_target[31:0]} from decode.
exc_bus  in  33  {exc_valid, exc_pc[31:0]} from write-back.
IF_over  out  1  IF_ID_bus holds a complete fetch this cycle.
IF_ID_bus  out  65  {pc[31:0], inst[31:0], fetch_error}; fetch_error is bit 0.
IF_pc  out  32  display copy of pc.
IF_inst  out  32  display copy of inst.

Behaviour:
- Reset (clk edge with reset=1):
  - pc <= RESET_PC, rom_ready_r <= 0, jbr_pend_r <= 0, jbr_pend_pc_r <= 0.
  - Outputs in the following cycle: inst_addr = RESET_PC, IF_over = 0.
  - Reset asserted mid-operation discards any pending redirect and any partial fetch.
- ROM latency:
  - rom_ready_r is cleared on every edge where pc changes.
  - It is set on the next edge where pc is unchanged and IF_valid=1.
  - IF_over = IF_valid & rom_ready_r & ~exc_valid.
  - Minimum fetch time: 2 cycles per instruction (address cycle plus data cycle).
- Next PC selection, strict priority:
  1. exc_valid: pc <= exc_pc regardless of next_fetch or IF_valid; jbr_pend_r <= 0. A same-cycle jbr_taken is ignored.
  2. next_fetch & jbr_taken: pc <= jbr_target; jbr_pend_r <= 0.
  3. next_fetch & jbr_pend_r: pc <= jbr_pend_pc_r; jbr_pend_r <= 0.
  4. next_fetch: pc <= pc + 4. Wraps modulo 2^32; 32'hFFFFFFFC advances to 32'h00000000.
  5. Otherwise pc holds.
- Pending branch:
  - When jbr_taken=1 and next_fetch=0 (and exc_valid=0), set jbr_pend_r <= 1 and jbr_pend_pc_r <= jbr_target.
  - A later jbr_taken overwrites the latched target.
- next_fetch is honoured only when IF_over=1. If next_fetch=1 while IF_over=0, the PC does not advance and the request is ignored.
- Fetch error:
  - fetch_error = (pc[1:0] != 2'b00).
  - When set, inst = NOP_INST and inst_rdata is ignored.
  - IF_over follows the same 2-cycle timing.
  - The PC sequence continues normally; write-back raises the exception and redirects through exc_bus.
- Output composition:
  - inst = fetch_error ? NOP_INST : inst_rdata.
  - IF_ID_bus = {pc, inst, fetch_error}.
  - IF_pc = pc, IF_inst = inst, all combinational.
- exc_valid is level-sampled, one pulse per redirect. A multi-cycle exc_valid re-loads exc_pc each cycle and holds IF_over low.

Test Plan:
- Reset: hold reset 3 cycles, then release with IF_valid=1, next_fetch=0.
  - Required: inst_addr=32'hBFC00000 immediately after reset.
  - IF_over=0 in the first cycle after release and 1 in the second.
  - IF_ID_bus={32'hBFC00000, rom[0], 0}.
- Sequential: next_fetch pulsed each time IF_over=1.
  - Required: PCs BFC00000, BFC00004, BFC00008.
  - Each IF_over preceded by exactly one cycle with IF_over=0.
- Pending branch: jbr_bus={1, 32'hBFC00100} while next_fetch=0; two cycles later next_fetch=1 and jbr_taken=0.
  - Required: pc=32'hBFC00100 on the following edge.
- Exception priority: exc_bus={1, 32'hBFC00380} in the same cycle as jbr_bus={1, 32'hBFC00200} and next_fetch=1.
  - Required: pc=32'hBFC00380, IF_over=0 that cycle, pending cleared.
  - The next next_fetch goes to BFC00384, not BFC00200.
- Misaligned: exc_bus redirect to 32'hBFC00002.
  - Required: IF_ID_bus={32'hBFC00002, 32'h00000000, 1} with IF_over=1 one cycle later.
  - inst_rdata content is ignored.
- Reset mid-branch: set a pending branch, assert reset one cycle, then release.
  - Required: pc=RESET_PC and the pending target is never taken.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM and
// presents {pc, inst, fetch_error} to decode, honouring exception and branch redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_valid,
    input  logic        next_fetch,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    output logic        IF_over,
    output logic [64:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    logic [31:0] r_pc;
    logic        r_rom_ready;
    logic        r_jbr_pend;
    logic [31:0] r_jbr_pend_pc;

    logic        w_exc_valid;
    logic [31:0] w_exc_pc;
    logic        w_jbr_taken;
    logic [31:0] w_jbr_target;
    logic        w_fetch_error;
    logic [31:0] w_inst;
    logic        w_advance;
    logic        w_pc_load;
    logic [31:0] w_next_pc;

    assign w_exc_valid  = exc_bus[32];
    assign w_exc_pc     = exc_bus[31:0];
    assign w_jbr_taken  = jbr_bus[32];
    assign w_jbr_target = jbr_bus[31:0];

    // A misaligned PC never reaches decode as a real instruction; write-back turns it into AdEL.
    assign w_fetch_error = (r_pc[1:0] != 2'b00);
    assign w_inst        = w_fetch_error ? NOP_INST : inst_rdata;

    assign IF_over   = IF_valid & r_rom_ready & ~w_exc_valid;
    assign w_advance = next_fetch & IF_over;
    assign w_pc_load = w_exc_valid | w_advance;

    assign inst_addr = r_pc;
    assign IF_ID_bus = {r_pc, w_inst, w_fetch_error};
    assign IF_pc     = r_pc;
    assign IF_inst   = w_inst;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_pc = r_pc;
        if (w_exc_valid) begin
            w_next_pc = w_exc_pc;
        end else if (w_advance) begin
            if (w_jbr_taken) begin
                w_next_pc = w_jbr_target;
            end else if (r_jbr_pend) begin
                w_next_pc = r_jbr_pend_pc;
            end else begin
                w_next_pc = r_pc + 32'd4;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_rom_ready   <= 1'b0;
            r_jbr_pend    <= 1'b0;
            r_jbr_pend_pc <= 32'h00000000;
        end else begin
            r_pc <= w_next_pc;

            // Any PC load restarts the two-cycle address/data handshake with the ROM.
            if (w_pc_load) begin
                r_rom_ready <= 1'b0;
            end else if (IF_valid) begin
                r_rom_ready <= 1'b1;
            end

            if (w_exc_valid || w_advance) begin
                r_jbr_pend <= 1'b0;
            end else if (w_jbr_taken) begin
                r_jbr_pend    <= 1'b1;
                r_jbr_pend_pc <= w_jbr_target;
            end
        end
    end

endmodule
